can_link_matrix: RTL and testbench

CAN_LINK_MATRIX -- requirements
Module: can_link_matrix

---
 rtl/can_link_matrix_pkg.sv | 20 ++
 rtl/can_link_matrix_delay_line.sv | 30 +++
 rtl/can_link_matrix.sv | 115 +++++++++++
 tb/tb_can_link_matrix.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/can_link_matrix_pkg.sv
// can_pkg: channel modes, bus levels and injection FSM states shared by the
// CAN link matrix and its delay lines.
package can_pkg;

    typedef enum logic [1:0] {
        PASS   = 2'd0,
        LOOP   = 2'd1,
        BUS    = 2'd2,
        SILENT = 2'd3
    } mode_e;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } inj_state_e;

    localparam logic RECESSIVE = 1'b1;
    localparam logic DOMINANT  = 1'b0;

endpackage

// File: rtl/can_link_matrix_delay_line.sv
// can_delay_line: per-channel recessive-filled shift line; tap 0 is the live
// input so the registered output of the top gives dly+1 cycles of latency.
module can_delay_line
    import can_pkg::*;
#(
    parameter  int MAX_DLY = 15,
    localparam int DW      = $clog2(MAX_DLY + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          d_i,
    input  logic [DW-1:0] dly_i,
    output logic          tap_o
);

    logic [MAX_DLY-1:0] line_q;
    logic [MAX_DLY:0]   taps;

    assign taps  = {line_q, d_i};
    assign tap_o = taps[dly_i];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            line_q <= {MAX_DLY{RECESSIVE}};
        end else begin
            line_q <= taps[MAX_DLY-1:0];
        end
    end

endmodule

// File: rtl/can_link_matrix.sv
// can_link_matrix: routes CAN controller TX/RX to transceivers, local loopback
// or a shared wired-AND bus, with per-channel delay and dominant-error injection.
module can_link_matrix
    import can_pkg::*;
#(
    parameter  int N_CH    = 4,
    parameter  int MAX_DLY = 15,
    parameter  int INJ_W   = 8,
    localparam int DW      = $clog2(MAX_DLY + 1),
    localparam int CW      = $clog2(N_CH)
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic [N_CH-1:0]  i_ctrl_tx,
    output logic [N_CH-1:0]  o_ctrl_rx,
    input  logic [N_CH-1:0]  i_phy_rx,
    output logic [N_CH-1:0]  o_phy_tx,
    input  logic             i_cfg_we,
    input  logic [CW-1:0]    i_cfg_ch,
    input  logic [1:0]       i_cfg_mode,
    input  logic [DW-1:0]    i_cfg_dly,
    input  logic             i_inj_start,
    input  logic [CW-1:0]    i_inj_ch,
    input  logic [INJ_W-1:0] i_inj_len,
    output logic             o_inj_busy
);

    localparam logic [DW:0]   DLY_LIM = (DW + 1)'(MAX_DLY);
    localparam logic [DW-1:0] DLY_MAX = DW'(MAX_DLY);

    mode_e            mode_q [N_CH];
    logic [DW-1:0]    dly_q  [N_CH];
    logic [DW-1:0]    dly_sat;
    logic [N_CH-1:0]  rx_q, rx_d, tx_q, tx_d, line_in, tap;
    logic             bus;
    inj_state_e       state_q, state_d;
    logic [INJ_W-1:0] cnt_q, cnt_d;
    logic [CW-1:0]    ch_q, ch_d;

    assign dly_sat    = ({1'b0, i_cfg_dly} > DLY_LIM) ? DLY_MAX : i_cfg_dly;
    assign o_ctrl_rx  = rx_q;
    assign o_phy_tx   = tx_q;
    assign o_inj_busy = (state_q == ACTIVE);

    // Wired-AND of every BUS-mode channel; idle-recessive when none joined.
    always_comb begin
        bus = RECESSIVE;
        for (int c = 0; c < N_CH; c++) begin
            bus &= (mode_q[c] != BUS) | i_ctrl_tx[c];
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        assign line_in[g] = (mode_q[g] == BUS) ? bus : i_ctrl_tx[g];
        can_delay_line #(.MAX_DLY(MAX_DLY)) u_dl (
            .clk_i (i_clk),
            .rst_ni(i_rstn),
            .d_i   (line_in[g]),
            .dly_i (dly_q[g]),
            .tap_o (tap[g])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ch_d    = ch_q;
        if (state_q == IDLE) begin
            if (i_inj_start && i_inj_len != '0) begin
                state_d = ACTIVE;
                cnt_d   = i_inj_len;
                ch_d    = i_inj_ch;
            end
        end else begin
            cnt_d   = cnt_q - INJ_W'(1);
            state_d = (cnt_q == INJ_W'(1)) ? IDLE : ACTIVE;
        end
    end

    // Force keys off the next state so busy and the dominant rx share an edge.
    always_comb begin
        rx_d = i_phy_rx;
        tx_d = {N_CH{RECESSIVE}};
        for (int c = 0; c < N_CH; c++) begin
            rx_d[c] = (mode_q[c] == LOOP || mode_q[c] == BUS) ? tap[c] : i_phy_rx[c];
            tx_d[c] = (mode_q[c] == PASS) ? i_ctrl_tx[c] : RECESSIVE;
        end
        if (state_d == ACTIVE) rx_d[ch_d] = DOMINANT;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            rx_q    <= {N_CH{RECESSIVE}};
            tx_q    <= {N_CH{RECESSIVE}};
            state_q <= IDLE;
            cnt_q   <= '0;
            ch_q    <= '0;
            for (int c = 0; c < N_CH; c++) begin
                mode_q[c] <= PASS;
                dly_q[c]  <= '0;
            end
        end else begin
            rx_q    <= rx_d;
            tx_q    <= tx_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ch_q    <= ch_d;
            if (i_cfg_we) begin
                mode_q[i_cfg_ch] <= mode_e'(i_cfg_mode);
                dly_q[i_cfg_ch]  <= dly_sat;
            end
        end
    end

endmodule

// File: tb/tb_can_link_matrix.sv
// tb_can_link_matrix: randomized and directed checks of can_link_matrix against
// a cycle-history reference model; a second instance covers delay saturation.
module tb_can_link_matrix;

    localparam int N   = 4;
    localparam int MD  = 15;
    localparam int SMD = 12;

    logic         clk = 1'b0, rst_n = 1'b0;
    logic [N-1:0] ctrl_tx = '1, phy_rx = '1, ctrl_rx, phy_tx;
    logic         cfg_we = 1'b0;
    logic [1:0]   cfg_ch = '0, cfg_mode = '0;
    logic [3:0]   cfg_dly = '0;
    logic         inj_start = 1'b0;
    logic [1:0]   inj_ch = '0;
    logic [7:0]   inj_len = '0;
    logic         busy;

    logic [N-1:0] s_ctrl_tx = '1, s_phy_rx = '1, s_ctrl_rx, s_phy_tx;
    logic         s_cfg_we = 1'b0;
    logic [1:0]   s_cfg_ch = 2'd0, s_cfg_mode = 2'd1, s_inj_ch = '0;
    logic [3:0]   s_cfg_dly = '0;
    logic         s_inj_start = 1'b0, s_busy;
    logic [7:0]   s_inj_len = '0;

    int           m_mode [N];
    int           m_dly  [N];
    int           hist   [N][MD+1];
    int           inj_left, inj_c;
    bit           prev_busy;
    logic [N-1:0] exp_rx, exp_tx, rx_mask;
    logic         exp_busy;
    int           tests = 0, fails = 0;

    always #5 clk = ~clk;

    can_link_matrix dut (
        .i_clk(clk), .i_rstn(rst_n),
        .i_ctrl_tx(ctrl_tx), .o_ctrl_rx(ctrl_rx),
        .i_phy_rx(phy_rx), .o_phy_tx(phy_tx),
        .i_cfg_we(cfg_we), .i_cfg_ch(cfg_ch), .i_cfg_mode(cfg_mode), .i_cfg_dly(cfg_dly),
        .i_inj_start(inj_start), .i_inj_ch(inj_ch), .i_inj_len(inj_len),
        .o_inj_busy(busy)
    );

    can_link_matrix #(.MAX_DLY(SMD)) u_sat (
        .i_clk(clk), .i_rstn(rst_n),
        .i_ctrl_tx(s_ctrl_tx), .o_ctrl_rx(s_ctrl_rx),
        .i_phy_rx(s_phy_rx), .o_phy_tx(s_phy_tx),
        .i_cfg_we(s_cfg_we), .i_cfg_ch(s_cfg_ch), .i_cfg_mode(s_cfg_mode), .i_cfg_dly(s_cfg_dly),
        .i_inj_start(s_inj_start), .i_inj_ch(s_inj_ch), .i_inj_len(s_inj_len),
        .o_inj_busy(s_busy)
    );

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            m_mode[c] = 0;
            m_dly[c]  = 0;
            for (int k = 0; k <= MD; k++) hist[c][k] = 1;
        end
        inj_left  = 0;
        prev_busy = 0;
        exp_rx    = '1;
        exp_tx    = '1;
        rx_mask   = '1;
        exp_busy  = 1'b0;
    endtask

    // hist[c][k] is what channel c's line saw k cycles ago; -1 = fed while
    // the channel was PASS/SILENT, which the rules leave undefined.
    task automatic model_edge();
        int bus, v;
        if (!rst_n) begin
            model_reset();
            return;
        end
        bus = 1;
        for (int c = 0; c < N; c++) if (m_mode[c] == 2 && !ctrl_tx[c]) bus = 0;
        rx_mask = '1;
        for (int c = 0; c < N; c++) begin
            for (int k = MD; k > 0; k--) hist[c][k] = hist[c][k-1];
            hist[c][0] = (m_mode[c] == 1) ? int'(ctrl_tx[c]) : (m_mode[c] == 2) ? bus : -1;
            if (m_mode[c] == 1 || m_mode[c] == 2) begin
                v          = hist[c][m_dly[c]];
                exp_rx[c]  = (v == 1);
                rx_mask[c] = (v >= 0);
                exp_tx[c]  = 1'b1;
            end else begin
                exp_rx[c] = phy_rx[c];
                exp_tx[c] = (m_mode[c] == 0) ? ctrl_tx[c] : 1'b1;
            end
        end
        if (!prev_busy && inj_start && inj_len != 0) begin
            inj_left = inj_len;
            inj_c    = inj_ch;
        end
        exp_busy = (inj_left > 0);
        if (exp_busy) begin
            exp_rx[inj_c]  = 1'b0;
            rx_mask[inj_c] = 1'b1;
            inj_left--;
        end
        prev_busy = exp_busy;
        if (cfg_we) begin
            m_mode[cfg_ch] = cfg_mode;
            m_dly[cfg_ch]  = (cfg_dly > MD) ? MD : cfg_dly;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic cfg(input int ch, input int mode, input int dly);
        cfg_we   = 1'b1;
        cfg_ch   = 2'(ch);
        cfg_mode = 2'(mode);
        cfg_dly  = 4'(dly);
        step();
        cfg_we = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (ctrl_rx !== 4'b1111) begin fails++; $display("FAIL reset_rx: got %b want 1111", ctrl_rx); end
        tests++;
        if (phy_tx !== 4'b1111) begin fails++; $display("FAIL reset_tx: got %b want 1111", phy_tx); end
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst_n = 1'b1;
    endtask

    task automatic test_pass();
        phy_rx  = 4'b1010;
        ctrl_tx = 4'b0110;
        step();
        tests++;
        if (ctrl_rx !== 4'b1010 || phy_tx !== 4'b0110) begin
            fails++;
            $display("FAIL pass_directed: rx=%b tx=%b want rx=1010 tx=0110", ctrl_rx, phy_tx);
        end
        for (int n = 0; n < 24; n++) begin
            ctrl_tx = 4'($urandom);
            phy_rx  = 4'($urandom);
            step();
            tests++;
            if ((ctrl_rx & rx_mask) !== (exp_rx & rx_mask) || phy_tx !== exp_tx || busy !== exp_busy) begin
                fails++;
                $display("FAIL pass_model: rx=%b tx=%b busy=%b want rx=%b tx=%b busy=%b", ctrl_rx, phy_tx, busy, exp_rx, exp_tx, exp_busy);
            end
        end
    endtask

    task automatic measure(input int dly, input int want, input string name);
        int lat;
        ctrl_tx = '1;
        phy_rx  = '1;
        cfg(0, 1, dly);
        repeat (MD + 2) step();
        ctrl_tx[0] = 1'b0;
        lat = 0;
        for (int n = 1; n <= 30; n++) begin
            step();
            ctrl_tx[0] = 1'b1;
            tests++;
            if ((ctrl_rx & rx_mask) !== (exp_rx & rx_mask) || phy_tx !== exp_tx || busy !== exp_busy) begin
                fails++;
                $display("FAIL %s_model: rx=%b tx=%b busy=%b want rx=%b tx=%b busy=%b", name, ctrl_rx, phy_tx, busy, exp_rx, exp_tx, exp_busy);
            end
            if (!ctrl_rx[0] && lat == 0) lat = n;
        end
        tests++;
        if (lat != want) begin fails++; $display("FAIL %s_latency: got %0d want %0d", name, lat, want); end
    endtask

    task automatic test_loop();
        measure(10, 11, "loop");
    endtask

    task automatic test_max_dly();
        measure(15, 16, "max_dly");
    endtask

    task automatic test_bus();
        ctrl_tx = '1;
        for (int c = 0; c < N; c++) cfg(c, 2, 0);
        repeat (2) step();
        ctrl_tx = 4'b1011;
        step();
        tests++;
        if (ctrl_rx !== 4'b0000 || phy_tx !== 4'b1111) begin
            fails++;
            $display("FAIL bus_dominant: rx=%b tx=%b want rx=0000 tx=1111", ctrl_rx, phy_tx);
        end
        ctrl_tx = '1;
        step();
        tests++;
        if (ctrl_rx !== 4'b1111) begin fails++; $display("FAIL bus_recessive: rx=%b want 1111", ctrl_rx); end
    endtask

    task automatic test_inject();
        int nb, nr;
        nb        = 0;
        nr        = 0;
        inj_start = 1'b1;
        inj_ch    = 2'd1;
        inj_len   = 8'd5;
        for (int n = 0; n < 12; n++) begin
            step();
            inj_start = (n == 1);
            inj_ch    = 2'd3;
            inj_len   = 8'd4;
            tests++;
            if ((ctrl_rx & rx_mask) !== (exp_rx & rx_mask) || phy_tx !== exp_tx || busy !== exp_busy) begin
                fails++;
                $display("FAIL inject_model: rx=%b tx=%b busy=%b want rx=%b tx=%b busy=%b", ctrl_rx, phy_tx, busy, exp_rx, exp_tx, exp_busy);
            end
            nb += int'(busy);
            nr += int'(!ctrl_rx[1]);
        end
        inj_start = 1'b0;
        tests++;
        if (nb != 5) begin fails++; $display("FAIL inject_busy_cycles: got %0d want 5", nb); end
        tests++;
        if (nr != 5) begin fails++; $display("FAIL inject_rx_cycles: got %0d want 5", nr); end
    endtask

    task automatic test_sat();
        int lat;
        s_cfg_we  = 1'b1;
        s_cfg_dly = 4'd15;
        step();
        s_cfg_we = 1'b0;
        repeat (SMD + 2) step();
        s_ctrl_tx[0] = 1'b0;
        lat = 0;
        for (int n = 1; n <= 30; n++) begin
            step();
            s_ctrl_tx[0] = 1'b1;
            if (!s_ctrl_rx[0] && lat == 0) lat = n;
        end
        tests++;
        if (lat != SMD + 1) begin fails++; $display("FAIL sat_latency: got %0d want %0d", lat, SMD + 1); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            ctrl_tx   = 4'($urandom) | 4'($urandom);
            phy_rx    = 4'($urandom);
            cfg_we    = ($urandom_range(7) == 0);
            cfg_ch    = 2'($urandom);
            cfg_mode  = 2'($urandom);
            cfg_dly   = 4'($urandom_range(MD));
            inj_start = ($urandom_range(15) == 0);
            inj_ch    = 2'($urandom);
            inj_len   = 8'($urandom_range(12));
            step();
            tests++;
            if ((ctrl_rx & rx_mask) !== (exp_rx & rx_mask) || phy_tx !== exp_tx || busy !== exp_busy) begin
                fails++;
                $display("FAIL random_model: cyc=%0d rx=%b tx=%b busy=%b want rx=%b(mask %b) tx=%b busy=%b", n, ctrl_rx, phy_tx, busy, exp_rx, rx_mask, exp_tx, exp_busy);
            end
        end
        cfg_we    = 1'b0;
        inj_start = 1'b0;
        repeat (20) step();
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < N; c++) cfg(c, 0, 0);
        ctrl_tx   = 4'b0000;
        phy_rx    = 4'b0101;
        inj_start = 1'b1;
        inj_ch    = 2'd2;
        inj_len   = 8'd10;
        step();
        inj_start = 1'b0;
        repeat (2) step();
        tests++;
        if (busy !== 1'b1 || phy_tx !== 4'b0000) begin
            fails++;
            $display("FAIL midinj_pre: busy=%b tx=%b want busy=1 tx=0000", busy, phy_tx);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (busy !== 1'b0 || ctrl_rx !== 4'b1111 || phy_tx !== 4'b1111) begin
            fails++;
            $display("FAIL midinj_reset: busy=%b rx=%b tx=%b want busy=0 rx=1111 tx=1111", busy, ctrl_rx, phy_tx);
        end
        model_reset();
        repeat (2) step();
        rst_n = 1'b1;
        repeat (3) begin
            step();
            tests++;
            if ((ctrl_rx & rx_mask) !== (exp_rx & rx_mask) || phy_tx !== exp_tx || busy !== exp_busy) begin
                fails++;
                $display("FAIL midinj_after: rx=%b tx=%b busy=%b want rx=%b tx=%b busy=%b", ctrl_rx, phy_tx, busy, exp_rx, exp_tx, exp_busy);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_pass();
        test_loop();
        test_bus();
        test_inject();
        test_max_dly();
        test_sat();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
